// File: rtl/icb_arb2.sv
// Two-master to one-slave ICB arbiter with a single outstanding transaction.
// Master 0 is instruction fetch, master 1 is the load/store unit.
module icb_arb2 #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic [PC_WIDTH-1:0]     m0_req_addr,
    input  logic                    m0_req_read,
    input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_req_wmask,
    output logic                    m0_resp_valid,
    input  logic                    m0_resp_ready,
    output logic                    m0_resp_err,
    output logic [DATA_WIDTH-1:0]   m0_resp_rdata,
    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic [PC_WIDTH-1:0]     m1_req_addr,
    input  logic                    m1_req_read,
    input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_req_wmask,
    output logic                    m1_resp_valid,
    input  logic                    m1_resp_ready,
    output logic                    m1_resp_err,
    output logic [DATA_WIDTH-1:0]   m1_resp_rdata,
    output logic                    s_req_valid,
    input  logic                    s_req_ready,
    output logic [PC_WIDTH-1:0]     s_req_addr,
    output logic                    s_req_read,
    output logic [DATA_WIDTH-1:0]   s_req_wdata,
    output logic [DATA_WIDTH/8-1:0] s_req_wmask,
    input  logic                    s_resp_valid,
    output logic                    s_resp_ready,
    input  logic                    s_resp_err,
    input  logic [DATA_WIDTH-1:0]   s_resp_rdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_rr;
    logic   r_owner;
    logic   r_hold;
    logic   r_hold_id;
    logic   w_any;
    logic   w_sel;
    logic   w_accept;
    logic   w_done;
    logic   w_owner_ready;

    // Grant selection; a stalled request keeps its grant until it is taken.
    always_comb begin
        w_any = m0_req_valid | m1_req_valid;
        w_sel = 1'b0;
        if (r_hold && (r_hold_id ? m1_req_valid : m0_req_valid)) begin
            w_sel = r_hold_id;
        end else if (m0_req_valid && m1_req_valid) begin
            w_sel = r_rr;
        end else if (m1_req_valid) begin
            w_sel = 1'b1;
        end else begin
            w_sel = 1'b0;
        end
    end

    // Handshake qualifiers and next-state decode.
    always_comb begin
        w_owner_ready = r_owner ? m1_resp_ready : m0_resp_ready;
        w_accept      = (r_state == ST_IDLE) && w_any && s_req_ready;
        w_done        = (r_state == ST_WAIT) && s_resp_valid && w_owner_ready;
        w_state_nxt   = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request and response routing; everything idles at zero.
    always_comb begin
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;
        m0_resp_valid = 1'b0;
        m0_resp_err   = 1'b0;
        m0_resp_rdata = '0;
        m1_resp_valid = 1'b0;
        m1_resp_err   = 1'b0;
        m1_resp_rdata = '0;
        s_req_valid   = 1'b0;
        s_req_addr    = '0;
        s_req_read    = 1'b0;
        s_req_wdata   = '0;
        s_req_wmask   = '0;
        s_resp_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && w_sel) begin
                    s_req_valid  = 1'b1;
                    s_req_addr   = m1_req_addr;
                    s_req_read   = m1_req_read;
                    s_req_wdata  = m1_req_wdata;
                    s_req_wmask  = m1_req_wmask;
                    m1_req_ready = s_req_ready;
                end else if (w_any) begin
                    s_req_valid  = 1'b1;
                    s_req_addr   = m0_req_addr;
                    s_req_read   = m0_req_read;
                    s_req_wdata  = m0_req_wdata;
                    s_req_wmask  = m0_req_wmask;
                    m0_req_ready = s_req_ready;
                end else begin
                    s_req_valid  = 1'b0;
                end
            end
            ST_WAIT: begin
                s_resp_ready = w_owner_ready;
                if (r_owner) begin
                    m1_resp_valid = s_resp_valid;
                    m1_resp_err   = s_resp_err;
                    m1_resp_rdata = s_resp_rdata;
                end else begin
                    m0_resp_valid = s_resp_valid;
                    m0_resp_err   = s_resp_err;
                    m0_resp_rdata = s_resp_rdata;
                end
            end
            default: s_resp_ready = 1'b0;
        endcase
    end

    // State, round-robin pointer, owner and stall-hold registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b0;
            r_owner   <= 1'b0;
            r_hold    <= 1'b0;
            r_hold_id <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= (r_state == ST_IDLE) && w_any && !s_req_ready;
            r_hold_id <= w_sel;
            if (w_accept) begin
                r_owner <= w_sel;
                r_rr    <= ~w_sel;
            end else begin
                r_owner <= r_owner;
                r_rr    <= r_rr;
            end
        end
    end

endmodule

// File: doc/icb_arb2.md
ICB_ARB2 -- requirements
Module: icb_arb2

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 32, address width of all request channels.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, width of wdata/rdata.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have ports m0_req_valid/m0_req_ready  input/output  1  request handshake of master 0 (fetch).
REQ-006 The block SHALL have ports m0_req_addr  input  PC_WIDTH, m0_req_read  input  1 (1=read), m0_req_wdata  input  DATA_WIDTH, m0_req_wmask  input  DATA_WIDTH/8.
REQ-007 The block SHALL have ports m0_resp_valid  output  1, m0_resp_ready  input  1, m0_resp_err  output  1, m0_resp_rdata  output  DATA_WIDTH.
REQ-008 The block SHALL have the same port set prefixed m1_ for master 1 (load/store unit), identical directions and widths.
REQ-009 The block SHALL have the same port set prefixed s_ for the single shared memory slave, all directions inverted.

Function
REQ-010 The block SHALL implement states IDLE and WAIT; at most one transaction outstanding on the slave.
REQ-011 In IDLE, requesting master set = {mi | mi_req_valid=1}; if one requester it SHALL be selected; if both, the master indicated by 1-bit round-robin pointer rr SHALL be selected.
REQ-012 In IDLE the selected master's addr/read/wdata/wmask SHALL drive s_req_*, s_req_valid = selected valid, selected mi_req_ready = s_req_ready (combinational); unselected mi_req_ready SHALL be 0.
REQ-013 With no requester in IDLE, s_req_valid SHALL be 0 and s_req_* data SHALL be 0.
REQ-014 On s_req_valid & s_req_ready in IDLE: latch owner = selected id, set rr = ~selected id, go to WAIT next cycle.
REQ-015 rr SHALL change only on an accepted request; a stalled request (s_req_ready=0) SHALL keep the same selection next cycle even if the other master asserts valid.
REQ-016 In WAIT, s_req_valid and both mi_req_ready SHALL be 0.
REQ-017 In WAIT, owner's resp_valid/err/rdata SHALL equal s_resp_valid/err/rdata and s_resp_ready SHALL equal owner's resp_ready; non-owner resp_valid SHALL be 0, resp_err 0, resp_rdata 0.
REQ-018 On s_resp_valid & s_resp_ready in WAIT: go to IDLE next cycle; no new request SHALL be accepted in that same cycle (one idle cycle minimum between transactions).
REQ-019 In IDLE, s_resp_ready SHALL be 0 and both mi_resp_valid 0; a spurious s_resp_valid SHALL be ignored.
REQ-020 Latency: request accepted cycle N, earliest response visible to master cycle N+1, same cycle as s_resp_valid (no added response latency).
REQ-021 The block SHALL route the response to owner regardless of current mi_req_valid values.

Reset
REQ-022 While rst_n=0 at a rising edge, state SHALL become IDLE, rr = 0 (master 0 favoured), owner = 0.
REQ-023 After reset, all outputs SHALL be 0 until a master asserts req_valid (m*_req_ready, m*_resp_valid, s_req_valid, s_resp_ready all 0).
REQ-024 Reset asserted in WAIT SHALL abandon the outstanding transaction; any subsequent late s_resp_valid in IDLE SHALL be ignored per REQ-019.

Verification
REQ-025 Single master: m0 read addr 0x100, s_req_ready=1, slave responds next cycle rdata 0x00000013 -> m0_resp_valid=1 with rdata 0x00000013, m1_resp_valid=0, state back to IDLE.
REQ-026 Contention after reset: m0 and m1 both valid same cycle, s_req_ready=1 -> m0 granted first, m1 granted on the next IDLE cycle, rr ends at 0.
REQ-027 Back-to-back contention held 4 transactions -> grant order m0, m1, m0, m1.
REQ-028 Stall: m1 alone valid, s_req_ready=0 for 3 cycles, m0 asserts valid in cycle 2 -> s_req_addr stays m1's address until accept; m1 owns response.
REQ-029 Response backpressure: owner m1 holds resp_ready=0 for 2 cycles with s_resp_valid=1, err=1 -> s_resp_ready=0 those cycles, m1 sees err=1 on accept, m0_resp_valid stays 0.
REQ-030 Reset in WAIT: rst_n=0 for 1 cycle while awaiting response, then s_resp_valid=1 -> no master resp_valid, s_resp_ready=0, next m1 request granted normally.
